id_ctrl_stage: RTL

Pipelined instruction-decode control stage for the RV32I core: decodes the ID-stage instruction into the datapath control bundle, registers it into the ID/EX boundary, and generates the pipeline stall for load-use hazards and multi-cycle multiply/divide. Successor to the combinational control decoder; adds an optional M-extension decode, illegal-instruction detection, flush handling and EX-hold sequencing. Sits between the IF/ID register and the EX stage; `stall_o` drives PC/IF-ID enables.

---
 rtl/id_ctrl_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/id_ctrl_stage.sv
// ID-stage control decoder with ID/EX bundle register, load-use bubble insertion
// and multi-cycle mul/div EX hold.
module id_ctrl_stage #(
    parameter bit M_EXT      = 1'b1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        inst_vld_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ex_vld_o,
    output logic        RegWEn_o,
    output logic        Bsel_o,
    output logic        Asel_o,
    output logic        MemRW_o,
    output logic        BrUn_o,
    output logic [3:0]  AluSel_o,
    output logic [2:0]  ImmSel_o,
    output logic [1:0]  WBSel_o,
    output logic        MulDiv_o,
    output logic [2:0]  MulDivOp_o,
    output logic [4:0]  ex_rd_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int          CW       = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

    typedef struct packed {
        logic       vld;
        logic       regwen;
        logic       bsel;
        logic       asel;
        logic       memrw;
        logic       brun;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] wb;
        logic       md;
        logic [2:0] mdop;
        logic [4:0] rd;
        logic       ill;
        logic       ld;
    } ctl_t;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic       w_is_r, w_is_i, w_is_load, w_is_s, w_is_b;
    logic       w_is_jal, w_is_lui, w_is_auipc, w_is_jalr;
    logic       w_m_op, w_r_ok, w_known, w_illegal;
    logic [3:0] w_alu;
    logic [2:0] w_imm;
    logic [1:0] w_wb;
    logic       w_rs1_use, w_rs2_use, w_load_use;
    ctl_t       w_dec;

    ctl_t          r_ex;
    logic [CW-1:0] r_cnt;

    assign w_opcode = inst_i[6:0];
    assign w_rd     = inst_i[11:7];
    assign w_f3     = inst_i[14:12];
    assign w_rs1    = inst_i[19:15];
    assign w_rs2    = inst_i[24:20];
    assign w_f7     = inst_i[31:25];

    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_s     = (w_opcode == OP_S);
    assign w_is_b     = (w_opcode == OP_B);
    assign w_is_jal   = (w_opcode == OP_JAL);
    assign w_is_lui   = (w_opcode == OP_LUI);
    assign w_is_auipc = (w_opcode == OP_AUIPC);
    assign w_is_jalr  = (w_opcode == OP_JALR);

    assign w_m_op    = w_is_r & (w_f7 == 7'b0000001) & M_EXT;
    assign w_r_ok    = (w_f7 == 7'b0000000) | (w_f7 == 7'b0100000) | w_m_op;
    assign w_known   = w_is_r | w_is_i | w_is_load | w_is_s | w_is_b |
                       w_is_jal | w_is_lui | w_is_auipc | w_is_jalr;
    assign w_illegal = ~w_known | (w_is_r & ~w_r_ok);

    always_comb begin
        w_alu = 4'b0000;
        w_imm = 3'b111;
        w_wb  = 2'b01;
        case (w_opcode)
            OP_R:     w_alu = w_m_op ? 4'b0000 : {w_f7[5], w_f3};
            OP_I: begin
                w_imm = 3'b000;
                // Only shifts take funct7[5]; other I-ops ignore imm[10].
                if (w_f3 == 3'b000)
                    w_alu = 4'b0000;
                else if (w_f3[1:0] == 2'b01)
                    w_alu = {w_f7[5], w_f3};
                else
                    w_alu = {1'b0, w_f3};
            end
            OP_LOAD: begin
                w_imm = 3'b000;
                w_wb  = 2'b00;
            end
            OP_S:     w_imm = 3'b001;
            OP_B:     w_imm = 3'b010;
            OP_JAL: begin
                w_imm = 3'b011;
                w_wb  = 2'b10;
            end
            OP_LUI: begin
                w_imm = 3'b100;
                w_alu = 4'b1111;
            end
            OP_AUIPC: w_imm = 3'b100;
            OP_JALR: begin
                w_imm = 3'b000;
                w_wb  = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_dec        = '0;
        w_dec.vld    = 1'b1;
        w_dec.regwen = ~(w_is_s | w_is_b | w_illegal);
        w_dec.bsel   = ~w_is_r;
        w_dec.asel   = w_is_b | w_is_jal | w_is_auipc;
        w_dec.memrw  = w_is_s;
        w_dec.brun   = w_is_b & (w_f3[2:1] == 2'b11);
        w_dec.alu    = w_alu;
        w_dec.imm    = w_imm;
        w_dec.wb     = w_wb;
        w_dec.md     = w_m_op;
        w_dec.mdop   = w_m_op ? w_f3 : 3'b000;
        w_dec.rd     = w_dec.regwen ? w_rd : 5'd0;
        w_dec.ill    = w_illegal;
        w_dec.ld     = w_is_load;
    end

    assign w_rs1_use  = w_is_r | w_is_i | w_is_load | w_is_s | w_is_b | w_is_jalr;
    assign w_rs2_use  = w_is_r | w_is_s | w_is_b;
    assign w_load_use = r_ex.vld & r_ex.ld & (r_ex.rd != 5'd0) & inst_vld_i &
                        ((w_rs1_use & (w_rs1 == r_ex.rd)) |
                         (w_rs2_use & (w_rs2 == r_ex.rd)));

    assign stall_o = ~flush_i & ((r_cnt != '0) | w_load_use);

    // A non-zero counter freezes EX; the op in ID waits until it reaches zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (flush_i) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end else if (w_load_use | ~inst_vld_i) begin
            r_ex  <= '0;
        end else begin
            r_ex  <= w_dec;
            r_cnt <= w_dec.md ? CNT_LOAD : '0;
        end
    end

    assign ex_vld_o   = r_ex.vld;
    assign RegWEn_o   = r_ex.regwen;
    assign Bsel_o     = r_ex.bsel;
    assign Asel_o     = r_ex.asel;
    assign MemRW_o    = r_ex.memrw;
    assign BrUn_o     = r_ex.brun;
    assign AluSel_o   = r_ex.alu;
    assign ImmSel_o   = r_ex.imm;
    assign WBSel_o    = r_ex.wb;
    assign MulDiv_o   = r_ex.md;
    assign MulDivOp_o = r_ex.mdop;
    assign ex_rd_o    = r_ex.rd;
    assign illegal_o  = r_ex.ill;

endmodule
